// File: rtl/maxpool3x3_reader.sv
// 3x3 / stride-2 / pad-1 max pooling over a channel-major feature map read through a
// synchronous single-port memory; emits one pooled pixel per valid/ready handshake.
module maxpool3x3_reader #(
    parameter int C      = 64,
    parameter int IN_H   = 56,
    parameter int IN_W   = 56,
    parameter int K      = 3,
    parameter int STRIDE = 2,
    parameter int PAD    = 1,
    parameter int DATA_W = 16,
    parameter int OUT_H  = (IN_H + 2*PAD - K) / STRIDE + 1,
    parameter int OUT_W  = (IN_W + 2*PAD - K) / STRIDE + 1,
    parameter int ADDR_W = $clog2(C*IN_H*IN_W)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic signed [DATA_W-1:0] rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_last
);

    localparam int CW   = (C > 1)     ? $clog2(C)     : 1;
    localparam int HW   = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int WW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int KW   = (K > 1)     ? $clog2(K)     : 1;
    localparam int PD_W = $clog2(((IN_H > IN_W) ? IN_H : IN_W) + 2*PAD + K) + 1;
    localparam logic signed [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, READ, DRAIN, EMIT, DONE} state_t;

    state_t                    state, state_nx;
    logic [CW-1:0]             c;
    logic [HW-1:0]             oh;
    logic [WW-1:0]             ow;
    logic [KW-1:0]             ky, kx;
    logic                      rd_pend;
    logic signed [DATA_W-1:0]  run_max;
    logic [PD_W-1:0]           py, px;
    logic                      in_bounds, tap_first, tap_last, pix_last;

    // Tap coordinates are kept in padded space so no signed arithmetic is needed.
    assign py        = PD_W'(oh) * PD_W'(STRIDE) + PD_W'(ky);
    assign px        = PD_W'(ow) * PD_W'(STRIDE) + PD_W'(kx);
    assign in_bounds = (py >= PD_W'(PAD)) && (py < PD_W'(IN_H + PAD)) &&
                       (px >= PD_W'(PAD)) && (px < PD_W'(IN_W + PAD));
    assign tap_first = (ky == '0) && (kx == '0);
    assign tap_last  = (ky == KW'(K-1)) && (kx == KW'(K-1));
    assign pix_last  = (c == CW'(C-1)) && (oh == HW'(OUT_H-1)) && (ow == WW'(OUT_W-1));
    assign out_data  = run_max;

    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        done      = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = READ;
            end
            READ: begin
                busy = 1'b1;
                if (in_bounds) begin
                    rd_en   = 1'b1;
                    rd_addr = ADDR_W'(c) * ADDR_W'(IN_H*IN_W) +
                              ADDR_W'(py - PD_W'(PAD)) * ADDR_W'(IN_W) +
                              ADDR_W'(px - PD_W'(PAD));
                end
                if (tap_last) state_nx = DRAIN;
            end
            DRAIN: begin
                busy     = 1'b1;
                state_nx = EMIT;
            end
            EMIT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = pix_last;
                if (out_ready) state_nx = pix_last ? DONE : READ;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            c     <= '0;
            oh    <= '0;
            ow    <= '0;
            ky    <= '0;
            kx    <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                c  <= '0;
                oh <= '0;
                ow <= '0;
                ky <= '0;
                kx <= '0;
            end
            if (state == READ) begin
                if (kx == KW'(K-1)) begin
                    kx <= '0;
                    ky <= tap_last ? '0 : ky + 1'b1;
                end else begin
                    kx <= kx + 1'b1;
                end
            end
            // Pixel order: ow fastest, then oh, then channel; wraps to zero after the last pixel.
            if (state == EMIT && out_ready) begin
                if (ow == WW'(OUT_W-1)) begin
                    ow <= '0;
                    if (oh == HW'(OUT_H-1)) begin
                        oh <= '0;
                        c  <= (c == CW'(C-1)) ? '0 : c + 1'b1;
                    end else begin
                        oh <= oh + 1'b1;
                    end
                end else begin
                    ow <= ow + 1'b1;
                end
            end
        end
    end

    // Read data lands one cycle after rd_en; padded taps never issue a read, so never compete.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend <= 1'b0;
            run_max <= '0;
        end else begin
            rd_pend <= rd_en;
            if (state == READ && tap_first)
                run_max <= MIN_VAL;
            else if (rd_pend && (rd_data > run_max))
                run_max <= rd_data;
        end
    end

endmodule
